// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: receive-side word handshake between the UART receiver and
// its consumer.
//
// Signals:
//   data_out    received word, stable while valid=1
//   valid       a word is held for the consumer
//   ready       consumer accepts the word when valid && ready
//   frame_err   stop bit of the held word was sampled 0
//   parity_err  parity mismatch for the held word
//   overrun     1-cycle pulse: a completed word was dropped
//
// Modports: master = receiver (drives the word), slave = consumer (drives ready).
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output data_out, valid, frame_err, parity_err, overrun,
    input  ready
  );

  modport slave (
    input  data_out, valid, frame_err, parity_err, overrun,
    output ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with configurable data width,
// start-bit validation, optional parity, frame/overrun reporting and a
// one-word hold register behind a valid/ready handshake.
//
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-low reset (release assumed synchronous to clk)
//   rx     in  serial line, idle high, asynchronous to clk
//   bus    uart_rx_param_if.master: data_out/valid/frame_err/parity_err/overrun out, ready in
//
// Parameters:
//   HALF_BIT_CYCLES  clk cycles per half bit (bit period = 2*HALF_BIT_CYCLES, min 2)
//   DATA_BITS        data bits per frame, 5..9, LSB first
//   PARITY_MODE      0 none, 1 odd, 2 even (only used when UART_RX_PARITY_EN is defined)
//
// Build option:
//   UART_RX_PARITY_EN  defined: PARITY state and checker are built.
//                      undefined: frame is start + DATA_BITS + stop, parity_err is 0.
module uart_rx_param #(
  parameter int HALF_BIT_CYCLES = 16,
  parameter int DATA_BITS       = 8,
  parameter int PARITY_MODE     = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  uart_rx_param_if.master   bus
);

  localparam int CW = $clog2(2 * HALF_BIT_CYCLES);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT_CYCLES - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(2 * HALF_BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIDX_LAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON  = (PARITY_MODE == 1) || (PARITY_MODE == 2);
  localparam bit PAR_ODD = (PARITY_MODE == 1);
`else
  // PARITY_MODE is ignored in this build; the expression is always 0.
  localparam bit PAR_ON  = 1'b0 && (PARITY_MODE != 0);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t               r_state, w_state_next;
  logic [CW-1:0]        r_cnt, w_cnt_next;
  logic [BW-1:0]        r_bidx, w_bidx_next;
  logic                 r_rx_s1, r_rx_s2;
  logic                 w_rx_s;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_shift_en;
  logic                 w_done;
  logic                 w_load;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_ovr;
`ifdef UART_RX_PARITY_EN
  logic                 w_par_smp;
  logic                 r_perr_acc;
  logic                 r_perr;
`endif

  assign w_rx_s = r_rx_s2;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bidx_next  = r_bidx;
    w_shift_en   = 1'b0;
    w_done       = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_smp    = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_next = S_START;
          w_cnt_next   = '0;
        end
      end
      S_START: begin
        if (r_cnt == HALF_LAST) begin
          // Start bit must still be low at its centre, else it was a glitch.
          w_cnt_next   = '0;
          w_bidx_next  = '0;
          w_state_next = w_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_next  = '0;
          w_shift_en  = 1'b1;
          w_bidx_next = r_bidx + BW'(1);
          if (r_bidx == BIDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = PAR_ON ? S_PARITY : S_STOP;
`else
            w_state_next = S_STOP;
`endif
          end
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_next   = '0;
          w_par_smp    = 1'b1;
          w_state_next = S_STOP;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
`endif
      S_STOP: begin
        // Leave for IDLE right after the mid-stop sample so a start edge
        // half a bit later (back-to-back frame) is caught.
        if (r_cnt == BIT_LAST) begin
          w_cnt_next   = '0;
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // A finished word is taken if the hold register is empty or being drained now.
  assign w_load = w_done && (!r_valid || bus.ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bidx  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr_acc <= 1'b0;
      r_perr     <= 1'b0;
`endif
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bidx  <= w_bidx_next;
      r_ovr   <= w_done && r_valid && !bus.ready;
`ifdef UART_RX_PARITY_EN
      if (r_state == S_IDLE) begin
        r_perr_acc <= 1'b0;
      end else if (w_par_smp) begin
        r_perr_acc <= PAR_ODD ? ~(^r_shift ^ w_rx_s) : (^r_shift ^ w_rx_s);
      end
`endif
      if (w_load) begin
        r_data  <= r_shift;
        r_ferr  <= ~w_rx_s;
        r_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
        r_perr  <= r_perr_acc;
`endif
      end else if (r_valid && bus.ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Shift register is pure datapath: LSB arrives first and ends up in bit 0.
  always_ff @(posedge clk) begin
    if (w_shift_en) begin
      r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
    end
  end

  assign bus.data_out  = r_data;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_ferr;
  assign bus.overrun   = r_ovr;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = r_perr;
`else
  assign bus.parity_err = PAR_ON;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;
  localparam int BITC = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rx1   = 1'b1;
  logic rx2   = 1'b1;

  always #5 clk = ~clk;

  uart_rx_param_if #(.DATA_BITS(8)) bus1 ();
  uart_rx_param_if #(.DATA_BITS(7)) bus2 ();

  uart_rx_param #(.HALF_BIT_CYCLES(4), .DATA_BITS(8), .PARITY_MODE(0)) dut1 (
    .clk(clk), .reset(reset), .rx(rx1), .bus(bus1.master)
  );
  uart_rx_param #(.HALF_BIT_CYCLES(4), .DATA_BITS(7), .PARITY_MODE(2)) dut2 (
    .clk(clk), .reset(reset), .rx(rx2), .bus(bus2.master)
  );

  typedef struct packed {
    logic [8:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    bit         stop;
    logic [7:0] exp_d;
    bit         exp_f;
  } vec_t;

  exp_t q1[$];
  exp_t q2[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ovr1     = 0;
  int pops1    = 0;
  int pops2    = 0;
  int t_start  = 0;
  int t_valid  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Scoreboard: every accepted word is popped and compared here.
  always @(negedge clk) begin
    exp_t e;
    if (reset && bus1.overrun) ovr1++;
    if (reset && bus1.valid && bus1.ready) begin
      pops1++;
      t_valid = cyc;
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut1_unexpected_word actual=%0h required=none", bus1.data_out);
      end else begin
        e = q1.pop_front();
        chk("dut1_data", 32'(bus1.data_out), 32'(e.data[7:0]));
        chk("dut1_frame_err", 32'(bus1.frame_err), 32'(e.ferr));
        chk("dut1_parity_err", 32'(bus1.parity_err), 32'(e.perr));
      end
    end
    if (reset && bus2.valid && bus2.ready) begin
      pops2++;
      if (q2.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut2_unexpected_word actual=%0h required=none", bus2.data_out);
      end else begin
        e = q2.pop_front();
        chk("dut2_data", 32'(bus2.data_out), 32'(e.data[6:0]));
        chk("dut2_frame_err", 32'(bus2.frame_err), 32'(e.ferr));
        chk("dut2_parity_err", 32'(bus2.parity_err), 32'(e.perr));
      end
    end
  end

  // All drive tasks start and end at posedge+1.
  task automatic idle(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int sel, input bit b);
    if (sel == 1) rx1 = b;
    else          rx2 = b;
    repeat (BITC) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int sel, input logic [8:0] d, input int nb,
                            input bit has_p, input bit p, input bit stop);
    t_start = cyc;
    drive_bit(sel, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(sel, d[i]);
    if (has_p) drive_bit(sel, p);
    drive_bit(sel, stop);
    if (sel == 1) rx1 = 1'b1;
    else          rx2 = 1'b1;
  endtask

  task automatic wait_drain(input int sel, input string nm);
    int n;
    for (int i = 0; i < 40; i++) begin
      n = (sel == 1) ? q1.size() : q2.size();
      if (n == 0) break;
      idle(1);
    end
    n = (sel == 1) ? q1.size() : q2.size();
    chk(nm, 32'(n), 32'd0);
  endtask

  vec_t tbl[6];

  initial begin
    int p0;
    tbl[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    tbl[1] = '{8'h81, 1'b0, 8'h81, 1'b1};
    tbl[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
    tbl[3] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    tbl[4] = '{8'h3C, 1'b1, 8'h3C, 1'b0};
    tbl[5] = '{8'h96, 1'b1, 8'h96, 1'b0};

    bus1.ready = 1'b1;
    bus2.ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus1.valid), 0);
    chk("rst_data", 32'(bus1.data_out), 0);
    chk("rst_frame_err", 32'(bus1.frame_err), 0);
    chk("rst_parity_err", 32'(bus1.parity_err), 0);
    chk("rst_overrun", 32'(bus1.overrun), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(5);

    // Table-driven frames with ready held high.
    for (int i = 0; i < 6; i++) begin
      q1.push_back('{data: {1'b0, tbl[i].exp_d}, ferr: tbl[i].exp_f, perr: 1'b0});
      send_frame(1, {1'b0, tbl[i].d}, 8, 1'b0, 1'b0, tbl[i].stop);
      if (i == 0) begin
        chk("a5_latency_in_70_80",
            32'((t_valid - t_start) >= 70 && (t_valid - t_start) <= 80), 1);
      end
      idle(12);
      wait_drain(1, "table_drain");
    end

    // Glitch: 2 clk low must not produce a word.
    p0 = pops1;
    rx1 = 1'b0;
    idle(2);
    rx1 = 1'b1;
    idle(20);
    chk("glitch_no_word", 32'(pops1), 32'(p0));
    q1.push_back('{data: 9'h05A, ferr: 1'b0, perr: 1'b0});
    send_frame(1, 9'h05A, 8, 1'b0, 1'b0, 1'b1);
    idle(4);
    wait_drain(1, "glitch_next_drain");

    // Overrun: two back-to-back words, consumer stalled.
    bus1.ready = 1'b0;
    ovr1 = 0;
    q1.push_back('{data: 9'h011, ferr: 1'b0, perr: 1'b0});
    send_frame(1, 9'h011, 8, 1'b0, 1'b0, 1'b1);
    send_frame(1, 9'h022, 8, 1'b0, 1'b0, 1'b1);
    idle(6);
    chk("ovr_pulses", 32'(ovr1), 1);
    chk("ovr_valid_held", 32'(bus1.valid), 1);
    chk("ovr_data_held", 32'(bus1.data_out), 32'h11);
    bus1.ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ovr_valid_drop", 32'(bus1.valid), 0);
    @(posedge clk);
    #1;
    wait_drain(1, "ovr_drain");

    // Reset in the middle of a frame.
    p0 = pops1;
    rx1 = 1'b0;
    idle(30);
    reset = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus1.valid), 0);
    chk("midrst_data", 32'(bus1.data_out), 0);
    chk("midrst_overrun", 32'(bus1.overrun), 0);
    chk("midrst_frame_err", 32'(bus1.frame_err), 0);
    rx1 = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(5);
    q1.push_back('{data: 9'h03C, ferr: 1'b0, perr: 1'b0});
    send_frame(1, 9'h03C, 8, 1'b0, 1'b0, 1'b1);
    idle(4);
    wait_drain(1, "midrst_next_drain");
    chk("midrst_one_word", 32'(pops1), 32'(p0 + 1));

    // 7-bit receiver; parity bit present only in the parity build (even mode).
`ifdef UART_RX_PARITY_EN
    q2.push_back('{data: 9'h007, ferr: 1'b0, perr: 1'b0});
    send_frame(2, 9'h007, 7, 1'b1, 1'b1, 1'b1);
    idle(4);
    wait_drain(2, "par_ok_drain");
    q2.push_back('{data: 9'h007, ferr: 1'b0, perr: 1'b1});
    send_frame(2, 9'h007, 7, 1'b1, 1'b0, 1'b1);
    idle(4);
    wait_drain(2, "par_bad_drain");
    q2.push_back('{data: 9'h07F, ferr: 1'b0, perr: 1'b0});
    send_frame(2, 9'h07F, 7, 1'b1, 1'b1, 1'b1);
    idle(4);
    wait_drain(2, "w7_drain");
    chk("dut2_words", 32'(pops2), 3);
`else
    q2.push_back('{data: 9'h007, ferr: 1'b0, perr: 1'b0});
    send_frame(2, 9'h007, 7, 1'b0, 1'b0, 1'b1);
    idle(4);
    wait_drain(2, "w7_07_drain");
    q2.push_back('{data: 9'h07F, ferr: 1'b0, perr: 1'b0});
    send_frame(2, 9'h07F, 7, 1'b0, 1'b0, 1'b1);
    idle(4);
    wait_drain(2, "w7_7f_drain");
    chk("dut2_words", 32'(pops2), 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
